// File: rtl/l2_mem_router.sv
// L2 line-request router: decodes each latched line address against the instruction
// window and services it from the ROM or the DDR, write-back first, with timeout recovery.
module l2_mem_router #(
  parameter int          TNUM         = 18,
  parameter int          INUM         = 8,
  parameter int unsigned INST_LINE_LO = 32'h402,
  parameter int unsigned INST_LINE_HI = 32'h47F,
  parameter int          TIMEOUT      = 1024
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            read_L2_MEM,
  input  logic            write_L2_MEM,
  input  logic [TNUM-1:0] tag_L2_MEM,
  input  logic [INUM-1:0] index_L2_MEM,
  input  logic [TNUM-1:0] write_tag_L2_MEM,
  input  logic [511:0]    write_data_L2_MEM,
  output logic [511:0]    read_data_MEM_L2,
  output logic            ready_MEM_L2,
  output logic            rom_read,
  output logic [TNUM-1:0] rom_tag,
  output logic [INUM-1:0] rom_index,
  input  logic            rom_ready,
  input  logic [511:0]    rom_data,
  output logic            ddr_read,
  output logic            ddr_write,
  output logic [TNUM-1:0] ddr_tag,
  output logic [INUM-1:0] ddr_index,
  output logic [511:0]    ddr_write_data,
  input  logic            ddr_ready,
  input  logic [511:0]    ddr_data,
  output logic            err_o,
  output logic [2:0]      dbg_state_o
);

  localparam int LAW = TNUM + INUM;
  localparam int CW  = $clog2(TIMEOUT + 1);

  // Handshakes: L2 holds read/write level-high until the one-cycle ready_MEM_L2 pulse;
  // target requests are levels held until the target's one-cycle ready pulse.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WB   = 3'd1,
    S_RD   = 3'd2,
    S_RESP = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [LAW-1:0]  rd_la_q, rd_la_d, wr_la_q, wr_la_d, ddr_la_q, ddr_la_d;
  logic [511:0]    wdata_q, wdata_d, rdata_q, rdata_d;
  logic            rd_pend_q, rd_pend_d, wr_pend_q, wr_pend_d;
  logic            rom_rd_q, rom_rd_d, ddr_rd_q, ddr_rd_d, ddr_wr_q, ddr_wr_d;
  logic            ready_q, ready_d, err_q, err_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [LAW-1:0]  req_rd_la, req_wr_la;
  logic            req_rd_inst, req_wr_inst, rd_inst, wr_inst;
  logic            timeout, tgt_ready, wb_done;
  logic [511:0]    tgt_data;

  function automatic logic in_inst(input logic [LAW-1:0] la);
    return (la >= LAW'(INST_LINE_LO)) && (la <= LAW'(INST_LINE_HI));
  endfunction

  assign req_rd_la   = {tag_L2_MEM, index_L2_MEM};
  assign req_wr_la   = {write_tag_L2_MEM, index_L2_MEM};
  assign req_rd_inst = in_inst(req_rd_la);
  assign req_wr_inst = in_inst(req_wr_la);
  assign rd_inst     = in_inst(rd_la_q);
  assign wr_inst     = in_inst(wr_la_q);
  assign timeout     = (cnt_q == CW'(TIMEOUT - 1));
  assign tgt_ready   = rom_rd_q ? rom_ready : ddr_ready;
  assign tgt_data    = rom_rd_q ? rom_data  : ddr_data;

  always_comb begin
    state_d   = state_q;
    rd_la_d   = rd_la_q;
    wr_la_d   = wr_la_q;
    ddr_la_d  = ddr_la_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    rd_pend_d = rd_pend_q;
    wr_pend_d = wr_pend_q;
    rom_rd_d  = rom_rd_q;
    ddr_rd_d  = ddr_rd_q;
    ddr_wr_d  = ddr_wr_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    wb_done   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (read_L2_MEM || write_L2_MEM) begin
          rd_la_d   = req_rd_la;
          wr_la_d   = req_wr_la;
          wdata_d   = write_data_L2_MEM;
          rd_pend_d = read_L2_MEM;
          wr_pend_d = write_L2_MEM;
          cnt_d     = '0;
          if (write_L2_MEM) begin
            state_d  = S_WB;
            ddr_wr_d = !req_wr_inst;
            if (!req_wr_inst) ddr_la_d = req_wr_la;
          end else begin
            state_d  = S_RD;
            rom_rd_d = req_rd_inst;
            ddr_rd_d = !req_rd_inst;
            if (!req_rd_inst) ddr_la_d = req_rd_la;
          end
        end
      end
      S_WB: begin
        // A write-back into the ROM window is refused without touching any target.
        if (wr_inst) begin
          err_d   = 1'b1;
          wb_done = 1'b1;
        end else if (ddr_ready) begin
          ddr_wr_d = 1'b0;
          wb_done  = 1'b1;
        end else if (timeout) begin
          ddr_wr_d = 1'b0;
          err_d    = 1'b1;
          state_d  = S_ERR;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
        if (wb_done) begin
          wr_pend_d = 1'b0;
          if (rd_pend_q) begin
            state_d  = S_RD;
            cnt_d    = '0;
            rom_rd_d = rd_inst;
            ddr_rd_d = !rd_inst;
            if (!rd_inst) ddr_la_d = rd_la_q;
          end else begin
            state_d = S_RESP;
          end
        end
      end
      S_RD: begin
        if (tgt_ready) begin
          rom_rd_d  = 1'b0;
          ddr_rd_d  = 1'b0;
          rdata_d   = tgt_data;
          rd_pend_d = 1'b0;
          state_d   = S_RESP;
        end else if (timeout) begin
          rom_rd_d  = 1'b0;
          ddr_rd_d  = 1'b0;
          rdata_d   = '0;
          err_d     = 1'b1;
          rd_pend_d = 1'b0;
          state_d   = S_ERR;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_ERR:   state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // The pulse is aligned with RESP, which never samples the still-high request.
    ready_d = (state_d == S_RESP);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      rd_la_q   <= '0;
      wr_la_q   <= '0;
      ddr_la_q  <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      rd_pend_q <= 1'b0;
      wr_pend_q <= 1'b0;
      rom_rd_q  <= 1'b0;
      ddr_rd_q  <= 1'b0;
      ddr_wr_q  <= 1'b0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      rd_la_q   <= rd_la_d;
      wr_la_q   <= wr_la_d;
      ddr_la_q  <= ddr_la_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      rd_pend_q <= rd_pend_d;
      wr_pend_q <= wr_pend_d;
      rom_rd_q  <= rom_rd_d;
      ddr_rd_q  <= ddr_rd_d;
      ddr_wr_q  <= ddr_wr_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign read_data_MEM_L2 = rdata_q;
  assign ready_MEM_L2     = ready_q;
  assign rom_read         = rom_rd_q;
  assign rom_tag          = rd_la_q[LAW-1:INUM];
  assign rom_index        = rd_la_q[INUM-1:0];
  assign ddr_read         = ddr_rd_q;
  assign ddr_write        = ddr_wr_q && wr_pend_q;
  assign ddr_tag          = ddr_la_q[LAW-1:INUM];
  assign ddr_index        = ddr_la_q[INUM-1:0];
  assign ddr_write_data   = wdata_q;
  assign err_o            = err_q;
  assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_l2_mem_router.sv
// Bench for l2_mem_router: directed cases plus randomized requests against a
// transaction-level model of routing, latency, returned data and error flag.
module tb_l2_mem_router;

  localparam int          TO = 16;
  localparam logic [25:0] LO = 26'h402;
  localparam logic [25:0] HI = 26'h47F;

  logic         clk = 1'b0;
  logic         rstn;
  logic         read_L2_MEM, write_L2_MEM;
  logic [17:0]  tag_L2_MEM, write_tag_L2_MEM;
  logic [7:0]   index_L2_MEM;
  logic [511:0] write_data_L2_MEM, read_data_MEM_L2;
  logic         ready_MEM_L2;
  logic         rom_read, rom_ready, ddr_read, ddr_write, ddr_ready, err_o;
  logic [17:0]  rom_tag, ddr_tag;
  logic [7:0]   rom_index, ddr_index;
  logic [511:0] rom_data, ddr_data, ddr_write_data;
  logic [2:0]   dbg_state;

  l2_mem_router #(
    .TNUM(18), .INUM(8), .INST_LINE_LO(32'h402), .INST_LINE_HI(32'h47F), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rstn(rstn),
    .read_L2_MEM(read_L2_MEM), .write_L2_MEM(write_L2_MEM),
    .tag_L2_MEM(tag_L2_MEM), .index_L2_MEM(index_L2_MEM),
    .write_tag_L2_MEM(write_tag_L2_MEM), .write_data_L2_MEM(write_data_L2_MEM),
    .read_data_MEM_L2(read_data_MEM_L2), .ready_MEM_L2(ready_MEM_L2),
    .rom_read(rom_read), .rom_tag(rom_tag), .rom_index(rom_index),
    .rom_ready(rom_ready), .rom_data(rom_data),
    .ddr_read(ddr_read), .ddr_write(ddr_write), .ddr_tag(ddr_tag), .ddr_index(ddr_index),
    .ddr_write_data(ddr_write_data), .ddr_ready(ddr_ready), .ddr_data(ddr_data),
    .err_o(err_o), .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int           n_checks = 0;
  int           n_fail   = 0;
  logic [511:0] exp_q[$];
  logic [511:0] model_data;
  logic         model_err;
  int           rom_wait, ddr_wait;
  logic [511:0] rom_line, ddr_line;
  logic         stray_ddr;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] rand_line();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  // Target models: ready pulse in cycle wait+1 of a continuously held request.
  initial begin
    int rc_rom, rc_rd, rc_wr;
    rc_rom = 0; rc_rd = 0; rc_wr = 0;
    rom_ready = 1'b0; ddr_ready = 1'b0; rom_data = '0; ddr_data = '0;
    forever begin
      @(negedge clk);
      rc_rom = rom_read  ? rc_rom + 1 : 0;
      rc_rd  = ddr_read  ? rc_rd + 1  : 0;
      rc_wr  = ddr_write ? rc_wr + 1  : 0;
      rom_ready = rom_read && (rc_rom == rom_wait + 1);
      ddr_ready = (ddr_read && (rc_rd == ddr_wait + 1)) ||
                  (ddr_write && (rc_wr == ddr_wait + 1)) || stray_ddr;
      rom_data  = rom_ready ? rom_line : rand_line();
      ddr_data  = (ddr_ready && !stray_ddr) ? ddr_line : rand_line();
    end
  end

  // One L2 transaction: model prediction, drive, observe, compare.
  task automatic run_txn(input string name, input bit rd, input bit wr,
                         input logic [25:0] rla, input logic [17:0] wtag,
                         input int rw, input int dw);
    logic [25:0]  wla;
    logic [511:0] wd, got_data;
    logic         got_err;
    bit           wr_legal, wr_to, rd_issued, rd_rom, rd_to;
    int           wph, rph, exp_rdy, k, rdy_k, n_rom, n_ddr_rd, n_ddr_wr, first_rd, bad, overlap;
    wla = {wtag, rla[7:0]};
    wd = rand_line();
    rom_wait = rw; ddr_wait = dw; rom_line = rand_line(); ddr_line = rand_line();
    wr_legal  = wr && !(wla >= LO && wla <= HI);
    wr_to     = wr_legal && (dw >= TO);
    wph       = !wr ? 0 : (!wr_legal ? 1 : (wr_to ? TO : dw + 1));
    rd_issued = rd && !wr_to;
    rd_rom    = (rla >= LO) && (rla <= HI);
    rd_to     = rd_issued && ((rd_rom ? rw : dw) >= TO);
    rph       = !rd_issued ? 0 : (rd_to ? TO : (rd_rom ? rw : dw) + 1);
    exp_rdy   = wph + rph + ((wr_to || rd_to) ? 1 : 0) + 1;
    if (rd_issued) model_data = rd_to ? '0 : (rd_rom ? rom_line : ddr_line);
    if ((wr && !wr_legal) || wr_to || rd_to) model_err = 1'b1;
    exp_q.push_back(model_data);

    @(negedge clk);
    read_L2_MEM = rd; write_L2_MEM = wr;
    tag_L2_MEM = rla[25:8]; index_L2_MEM = rla[7:0];
    write_tag_L2_MEM = wtag; write_data_L2_MEM = wd;
    k = 0; rdy_k = -1; n_rom = 0; n_ddr_rd = 0; n_ddr_wr = 0; first_rd = 0; bad = 0; overlap = 0;
    got_data = 'x; got_err = 1'bx;
    while (rdy_k < 0 && k < 100) begin
      @(negedge clk);
      k++;
      if (rom_read) begin
        n_rom++;
        if (first_rd == 0) first_rd = k;
        if ({rom_tag, rom_index} !== rla) bad++;
      end
      if (ddr_read) begin
        n_ddr_rd++;
        if (first_rd == 0) first_rd = k;
        if ({ddr_tag, ddr_index} !== rla) bad++;
      end
      if (ddr_write) begin
        n_ddr_wr++;
        if ({ddr_tag, ddr_index} !== wla || ddr_write_data !== wd) bad++;
      end
      if (int'(rom_read) + int'(ddr_read) + int'(ddr_write) > 1) overlap++;
      if (ready_MEM_L2) begin
        rdy_k = k; got_data = read_data_MEM_L2; got_err = err_o;
      end
    end
    // L2 drops its level only after it has seen the ready edge.
    @(posedge clk);
    #1;
    read_L2_MEM = 1'b0; write_L2_MEM = 1'b0;
    chk({name, ":ready_seen"}, 512'(rdy_k >= 0), 512'(1));
    chk({name, ":latency"}, 512'(rdy_k), 512'(exp_rdy));
    chk({name, ":rdata"}, got_data, exp_q.pop_front());
    chk({name, ":err"}, 512'(got_err), 512'(model_err));
    chk({name, ":rom_cycles"}, 512'(n_rom), 512'((rd_issued && rd_rom) ? rph : 0));
    chk({name, ":ddr_rd_cycles"}, 512'(n_ddr_rd), 512'((rd_issued && !rd_rom) ? rph : 0));
    chk({name, ":ddr_wr_cycles"}, 512'(n_ddr_wr), 512'(wr_legal ? wph : 0));
    chk({name, ":rd_start"}, 512'(first_rd), 512'(rd_issued ? wph + 1 : 0));
    chk({name, ":addr_data"}, 512'(bad), 512'(0));
    chk({name, ":overlap"}, 512'(overlap), 512'(0));
    @(negedge clk);
    chk({name, ":quiet_after"}, 512'({ready_MEM_L2, rom_read, ddr_read, ddr_write}), 512'(0));
  endtask

  initial begin
    int cnt;
    read_L2_MEM = 1'b0; write_L2_MEM = 1'b0; tag_L2_MEM = '0; index_L2_MEM = '0;
    write_tag_L2_MEM = '0; write_data_L2_MEM = '0; stray_ddr = 1'b0;
    rom_wait = 0; ddr_wait = 0; rom_line = '0; ddr_line = '0;
    model_data = '0; model_err = 1'b0;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset:rdata", read_data_MEM_L2, '0);
    chk("reset:ctrl", 512'({ready_MEM_L2, rom_read, ddr_read, ddr_write, err_o}), 512'(0));
    chk("reset:addr", 512'({rom_tag, rom_index, ddr_tag, ddr_index}), 512'(0));
    rstn = 1'b1;

    // directed
    run_txn("rom_first_line", 1, 0, 26'h402, 18'h0, 2, 0);
    run_txn("ddr_past_hi", 1, 0, 26'h480, 18'h0, 0, 20);
    run_txn("wb_then_rom_hi", 1, 1, 26'h47F, 18'h5, 2, 4);
    run_txn("rom_write_only", 0, 1, 26'h410, 18'h4, 0, 0);
    run_txn("ddr_timeout", 1, 0, 26'h01234, 18'h0, 0, 1000);
    run_txn("ddr_below_lo", 1, 0, 26'h401, 18'h0, 0, 3);
    run_txn("wb_timeout", 1, 1, 26'h0040A, 18'h9, 1, 1000);

    // target ready outside WB/RD
    @(negedge clk); #1 stray_ddr = 1'b1;
    @(negedge clk); #1 stray_ddr = 1'b0;
    cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (ready_MEM_L2) cnt++;
    end
    chk("stray:no_ready", 512'(cnt), 512'(0));
    chk("stray:rdata", read_data_MEM_L2, model_data);

    // reset during an outstanding ddr_read
    ddr_wait = 1000;
    @(negedge clk);
    read_L2_MEM = 1'b1; tag_L2_MEM = 18'h3; index_L2_MEM = 8'h21;
    repeat (5) @(negedge clk);
    chk("rst_mid:ddr_read_up", 512'(ddr_read), 512'(1));
    #2 rstn = 1'b0;
    #1;
    chk("rst_mid:ctrl", 512'({ready_MEM_L2, rom_read, ddr_read, ddr_write, err_o}), 512'(0));
    chk("rst_mid:rdata", read_data_MEM_L2, '0);
    read_L2_MEM = 1'b0;
    model_data = '0; model_err = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (ready_MEM_L2 || ddr_read) cnt++;
    end
    chk("rst_mid:no_ready", 512'(cnt), 512'(0));
    run_txn("after_reset", 1, 0, 26'h47E, 18'h0, 1, 0);

    // randomized
    for (int t = 0; t < 30; t++) begin
      logic [25:0] la;
      logic [17:0] wt;
      bit          rd, wr;
      case ($urandom_range(0, 5))
        0:       la = 26'h401;
        1:       la = 26'h402;
        2:       la = 26'h47F;
        3:       la = 26'h480;
        default: la = 26'($urandom());
      endcase
      wt = $urandom_range(0, 1) == 1 ? 18'h4 : 18'($urandom());
      do begin
        rd = 1'($urandom_range(0, 1));
        wr = 1'($urandom_range(0, 1));
      end while (!rd && !wr);
      run_txn("random", rd, wr, la, wt, int'($urandom_range(0, 17)), int'($urandom_range(0, 17)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
